// File: rtl/register_file_if.sv
// rtl/register_file_if.sv - RoB commit, dispatcher rename and operand lookup bus for register_file
interface register_file_if #(
    parameter int RoB_WIDTH = 3
);
    logic                 rdy_in;
    logic                 flush_in;
    logic                 commit_en;
    logic [5:0]           commit_reg;
    logic [RoB_WIDTH-1:0] commit_index;
    logic [31:0]          commit_data;
    logic                 rename_en;
    logic [4:0]           rename_rd;
    logic [RoB_WIDTH-1:0] rename_index;
    logic [4:0]           rs1_in;
    logic [4:0]           rs2_in;
    logic                 rs1_ready;
    logic [31:0]          rs1_value;
    logic [RoB_WIDTH-1:0] rs1_tag;
    logic                 rs2_ready;
    logic [31:0]          rs2_value;
    logic [RoB_WIDTH-1:0] rs2_tag;

    modport master (
        output rdy_in, flush_in, commit_en, commit_reg, commit_index, commit_data,
        output rename_en, rename_rd, rename_index, rs1_in, rs2_in,
        input  rs1_ready, rs1_value, rs1_tag, rs2_ready, rs2_value, rs2_tag
    );

    modport slave (
        input  rdy_in, flush_in, commit_en, commit_reg, commit_index, commit_data,
        input  rename_en, rename_rd, rename_index, rs1_in, rs2_in,
        output rs1_ready, rs1_value, rs1_tag, rs2_ready, rs2_value, rs2_tag
    );
endinterface

// File: rtl/register_file.sv
// rtl/register_file.sv - architectural register file with rename tags; REGISTER_FILE_BYPASS_EN enables commit-to-read bypass
module register_file #(
    parameter int RoB_WIDTH = 3,
    parameter int REG_NUM   = 32
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    register_file_if.slave    rf
);
    typedef struct packed {
        logic                 ready;
        logic [31:0]          value;
        logic [RoB_WIDTH-1:0] tag;
    } lookup_t;

    logic [31:0]          value_q [REG_NUM];
    logic [31:0]          value_d [REG_NUM];
    logic [RoB_WIDTH-1:0] tag_q   [REG_NUM];
    logic [RoB_WIDTH-1:0] tag_d   [REG_NUM];
    logic [REG_NUM-1:0]   busy_q;
    logic [REG_NUM-1:0]   busy_d;

    logic [4:0] commit_r;
    logic       unused_commit_msb;
    lookup_t    rd1;
    lookup_t    rd2;

    assign commit_r          = rf.commit_reg[4:0];
    assign unused_commit_msb = rf.commit_reg[5];

    // Rename is applied after commit so a same-cycle rename of the committing register keeps it busy.
    always_comb begin
        value_d = value_q;
        tag_d   = tag_q;
        busy_d  = busy_q;
        if (rf.rdy_in) begin
            if (rf.commit_en && commit_r != 5'd0) begin
                value_d[commit_r] = rf.commit_data;
                if (busy_q[commit_r] && tag_q[commit_r] == rf.commit_index)
                    busy_d[commit_r] = 1'b0;
            end
            if (rf.flush_in) begin
                busy_d = '0;
            end else if (rf.rename_en && rf.rename_rd != 5'd0) begin
                busy_d[rf.rename_rd] = 1'b1;
                tag_d[rf.rename_rd]  = rf.rename_index;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < REG_NUM; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
            busy_q <= '0;
        end else begin
            value_q <= value_d;
            tag_q   <= tag_d;
            busy_q  <= busy_d;
        end
    end

    function automatic lookup_t lookup(input logic [4:0] rs);
        lookup_t r;
        r.ready = 1'b1;
        r.value = value_q[rs];
        r.tag   = '0;
        if (busy_q[rs]) begin
            r.ready = 1'b0;
            r.tag   = tag_q[rs];
        end
`ifdef REGISTER_FILE_BYPASS_EN
        if (rf.commit_en && commit_r == rs && busy_q[rs] && tag_q[rs] == rf.commit_index) begin
            r.ready = 1'b1;
            r.value = rf.commit_data;
            r.tag   = '0;
        end
`endif
        return r;
    endfunction

    assign rd1 = lookup(rf.rs1_in);
    assign rd2 = lookup(rf.rs2_in);

    assign rf.rs1_ready = rd1.ready;
    assign rf.rs1_value = rd1.value;
    assign rf.rs1_tag   = rd1.tag;
    assign rf.rs2_ready = rd2.ready;
    assign rf.rs2_value = rd2.value;
    assign rf.rs2_tag   = rd2.tag;
endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - scoreboard bench for register_file operand lookups
module tb_register_file;
    logic clk;
    logic rst_n;

    register_file_if #(.RoB_WIDTH(3)) rf_if ();

    register_file #(.RoB_WIDTH(3), .REG_NUM(32)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .rf       (rf_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          port;
        bit          rdy;
        bit          chk_val;
        logic [31:0] val;
        bit          chk_tag;
        logic [2:0]  tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic exp_ready(input string name, input bit port, input logic [31:0] val);
        exp_t e;
        e.name = name; e.port = port; e.rdy = 1'b1;
        e.chk_val = 1'b1; e.val = val; e.chk_tag = 1'b1; e.tag = 3'd0;
        sb.push_back(e);
    endtask

    task automatic exp_busy(input string name, input bit port, input logic [2:0] tag,
                            input bit chk_val, input logic [31:0] val);
        exp_t e;
        e.name = name; e.port = port; e.rdy = 1'b0;
        e.chk_val = chk_val; e.val = val; e.chk_tag = 1'b1; e.tag = tag;
        sb.push_back(e);
    endtask

    // Outputs are combinational; whatever was queued for this cycle is compared mid-cycle.
    initial begin
        exp_t        e;
        logic        a_rdy;
        logic [31:0] a_val;
        logic [2:0]  a_tag;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e     = sb.pop_front();
                a_rdy = e.port ? rf_if.rs2_ready : rf_if.rs1_ready;
                a_val = e.port ? rf_if.rs2_value : rf_if.rs1_value;
                a_tag = e.port ? rf_if.rs2_tag   : rf_if.rs1_tag;
                checks++;
                if (a_rdy !== e.rdy || (e.chk_val && a_val !== e.val) || (e.chk_tag && a_tag !== e.tag)) begin
                    errors++;
                    $display("FAIL %s: got ready=%0b value=%h tag=%0d, want ready=%0b value=%h tag=%0d",
                             e.name, a_rdy, a_val, a_tag, e.rdy, e.val, e.tag);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        rf_if.rdy_in    = 1'b1;
        rf_if.flush_in  = 1'b0;
        rf_if.commit_en = 1'b0;
        rf_if.rename_en = 1'b0;
    endtask

    task automatic do_commit(input logic [5:0] r, input logic [2:0] idx, input logic [31:0] d);
        rf_if.commit_en = 1'b1; rf_if.commit_reg = r; rf_if.commit_index = idx; rf_if.commit_data = d;
    endtask

    task automatic do_rename(input logic [4:0] rd, input logic [2:0] idx);
        rf_if.rename_en = 1'b1; rf_if.rename_rd = rd; rf_if.rename_index = idx;
    endtask

    task automatic rd(input logic [4:0] r1, input logic [4:0] r2);
        rf_if.rs1_in = r1; rf_if.rs2_in = r2;
    endtask

    initial begin
        rst_n = 1'b0;
        rf_if.rdy_in = 1'b1; rf_if.flush_in = 1'b0;
        rf_if.commit_en = 1'b0; rf_if.commit_reg = '0; rf_if.commit_index = '0; rf_if.commit_data = '0;
        rf_if.rename_en = 1'b0; rf_if.rename_rd = '0; rf_if.rename_index = '0;
        rf_if.rs1_in = '0; rf_if.rs2_in = '0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        rd(5'd5, 5'd31);
        exp_ready("reset_rs1_x5", 0, 32'h0);
        exp_ready("reset_rs2_x31", 1, 32'h0);
        tick();

        // Rename then commit; read in rename cycle sees the old state
        do_rename(5'd3, 3'd2);
        rd(5'd3, 5'd0);
        exp_ready("rename_same_cycle_read", 0, 32'h0);
        tick();
        exp_busy("x3_busy_tag2", 0, 3'd2, 1'b0, 32'h0);
        tick();
        do_commit(6'h23, 3'd2, 32'hDEADBEEF);
        tick();
        exp_ready("x3_committed", 0, 32'hDEADBEEF);
        tick();

        // Stale commit leaves the younger rename busy
        do_rename(5'd4, 3'd1);
        tick();
        do_rename(5'd4, 3'd5);
        tick();
        do_commit(6'd4, 3'd1, 32'd7);
        tick();
        rd(5'd4, 5'd0);
        exp_busy("x4_stale_commit", 0, 3'd5, 1'b1, 32'd7);
        tick();
        do_commit(6'd4, 3'd5, 32'd9);
        tick();
        exp_ready("x4_final_commit", 0, 32'd9);
        tick();

        // Commit and rename of the same register in one cycle
        do_commit(6'd6, 3'd0, 32'h11);
        do_rename(5'd6, 3'd3);
        tick();
        rd(5'd6, 5'd0);
        exp_busy("x6_collision", 0, 3'd3, 1'b1, 32'h11);
        tick();
        do_commit(6'd6, 3'd3, 32'h22);
        tick();
        exp_ready("x6_after_commit", 0, 32'h22);
        tick();

        // Flush clears busy bits, ignores rename, still takes the commit value
        do_commit(6'd1, 3'd0, 32'hA1);
        tick();
        do_rename(5'd1, 3'd1);
        tick();
        do_rename(5'd2, 3'd2);
        tick();
        do_rename(5'd7, 3'd6);
        tick();
        rd(5'd1, 5'd7);
        exp_busy("x1_busy_pre_flush", 0, 3'd1, 1'b1, 32'hA1);
        exp_busy("x7_busy_pre_flush", 1, 3'd6, 1'b0, 32'h0);
        rf_if.flush_in = 1'b1;
        do_rename(5'd8, 3'd7);
        do_commit(6'd7, 3'd5, 32'h77);
        tick();
        rd(5'd1, 5'd2);
        exp_ready("x1_after_flush", 0, 32'hA1);
        exp_ready("x2_after_flush", 1, 32'h0);
        tick();
        rd(5'd7, 5'd8);
        exp_ready("x7_after_flush", 0, 32'h77);
        exp_ready("x8_not_renamed", 1, 32'h0);
        tick();

        // x0 is immutable
        do_commit(6'd0, 3'd4, 32'hFFFFFFFF);
        do_rename(5'd0, 3'd4);
        tick();
        rd(5'd0, 5'd0);
        exp_ready("x0_rs1", 0, 32'h0);
        exp_ready("x0_rs2", 1, 32'h0);
        tick();

        // rdy_in low: outputs still combinational, no state change
        do_rename(5'd9, 3'd4);
        tick();
        rf_if.rdy_in = 1'b0;
        do_commit(6'd9, 3'd4, 32'h55);
        do_rename(5'd10, 3'd2);
        rd(5'd10, 5'd9);
`ifdef REGISTER_FILE_BYPASS_EN
        exp_ready("x9_hold_bypass", 1, 32'h55);
`else
        exp_busy("x9_hold_nobypass", 1, 3'd4, 1'b0, 32'h0);
`endif
        tick();
        exp_ready("x10_held_not_renamed", 0, 32'h0);
        exp_busy("x9_held_busy", 1, 3'd4, 1'b1, 32'h0);
        tick();

        // Commit while reading the same register
        do_commit(6'd9, 3'd4, 32'h55);
        rd(5'd0, 5'd9);
`ifdef REGISTER_FILE_BYPASS_EN
        exp_ready("x9_bypass", 1, 32'h55);
`else
        exp_busy("x9_no_bypass", 1, 3'd4, 1'b0, 32'h0);
`endif
        tick();
        exp_ready("x9_after_commit", 1, 32'h55);
        tick();
        tick();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
